// File: rtl/cnn_window_gen.sv
// K x K sliding-window generator: buffers K-1 raster rows and emits one registered
// window per in-image, stride-aligned position, with frame-end marking.
module cnn_window_gen #(
   parameter int DATA_W = 9,
   parameter int IMG_W  = 32,
   parameter int IMG_H  = 32,
   parameter int K      = 5,
   parameter int STRIDE = 1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    in_valid,
   input  logic                    in_sof,
   input  logic [DATA_W-1:0]       in_data,
   output logic                    out_valid,
   output logic                    out_eof,
   output logic [K*K*DATA_W-1:0]   win
);
   localparam int XW     = $clog2(IMG_W);
   localparam int YW     = $clog2(IMG_H);
   localparam int PW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
   localparam int X_LAST = K - 1 + ((IMG_W - K) / STRIDE) * STRIDE;
   localparam int Y_LAST = K - 1 + ((IMG_H - K) / STRIDE) * STRIDE;

   localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_K   = XW'(K - 1);
   localparam logic [YW-1:0] Y_K   = YW'(K - 1);
   localparam logic [XW-1:0] X_L   = XW'(X_LAST);
   localparam logic [YW-1:0] Y_L   = YW'(Y_LAST);
   localparam logic [PW-1:0] PH_MAX = PW'(STRIDE - 1);

   logic [XW-1:0] x, ex;
   logic [YW-1:0] y, ey;
   logic [PW-1:0] px, py, epx, epy, npx, npy;
   logic          emit, last;

   // lb_chain[0] is the incoming pixel, lb_chain[j] the same column j rows above
   logic [K-1:0][DATA_W-1:0]         lb_chain;
   logic [K-1:0][K-1:0][DATA_W-1:0]  sh, nxt;

   assign lb_chain[0] = in_data;

   for (genvar j = 0; j < K - 1; j++) begin : g_lb
      lb_row #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb (
         .clk  (clk),
         .en   (in_valid),
         .din  (lb_chain[j]),
         .dout (lb_chain[j+1])
      );
   end

   // An in_sof pixel is (0,0) whatever the counters say; phases restart at K-1
   always_comb begin
      ex   = in_sof ? '0 : x;
      ey   = in_sof ? '0 : y;
      epx  = (ex == X_K) ? '0 : px;
      epy  = (ey == Y_K) ? '0 : py;
      npx  = (epx == PH_MAX) ? '0 : epx + 1'b1;
      npy  = (epy == PH_MAX) ? '0 : epy + 1'b1;
      emit = in_valid && (ex >= X_K) && (ey >= Y_K) && (epx == '0) && (epy == '0);
      last = (ex == X_L) && (ey == Y_L);
   end

   always_comb begin
      nxt = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++)
            nxt[r][c] = sh[r][c+1];
         nxt[r][K-1] = lb_chain[K-1-r];
      end
   end

   // Shifting window shadow; its contents only matter once K-1 fresh rows exist
   always_ff @(posedge clk)
      if (in_valid) sh <= nxt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x         <= '0;
         y         <= '0;
         px        <= '0;
         py        <= '0;
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         win       <= '0;
      end else begin
         out_valid <= emit;
         out_eof   <= emit && last;
         if (emit) win <= nxt;
         if (in_valid) begin
            px <= npx;
            if (ex == X_MAX) begin
               x  <= '0;
               y  <= (ey == Y_MAX) ? '0 : ey + 1'b1;
               py <= npy;
            end else begin
               x  <= ex + 1'b1;
               y  <= ey;
            end
         end
      end
   end
endmodule

// One image row of delay, as a shift register advanced on accepted pixels.
module lb_row #(
   parameter int DATA_W = 9,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);
   logic [DEPTH-1:0][DATA_W-1:0] sr;

   always_ff @(posedge clk)
      if (en) sr <= {sr[DEPTH-2:0], din};

   assign dout = sr[DEPTH-1];
endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench: 6x6 image, K=3, 8-bit pixels, stride 1 and stride 2 instances
// fed by the same stream, pixel value = y*6+x.
module tb_cnn_window_gen;
   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid, in_sof;
   logic [7:0]  in_data;
   logic        ov1, oe1, ov2, oe2;
   logic [71:0] win1, win2;
   logic [71:0] w1, w2;
   int          checks = 0, errors = 0;
   int          nv1, ne1, nv2, ne2;

   always #5 clk = ~clk;

   cnn_window_gen #(.DATA_W(8), .IMG_W(6), .IMG_H(6), .K(3), .STRIDE(1)) u_s1 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(ov1), .out_eof(oe1), .win(win1));

   cnn_window_gen #(.DATA_W(8), .IMG_W(6), .IMG_H(6), .K(3), .STRIDE(2)) u_s2 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .out_valid(ov2), .out_eof(oe2), .win(win2));

   function automatic logic [71:0] wexp(input int x, input int y);
      logic [71:0] w;
      w = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            w[(r*3+c)*8 +: 8] = 8'((y - 2 + r) * 6 + (x - 2 + c));
      return w;
   endfunction

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic clr_cnt();
      nv1 = 0; ne1 = 0; nv2 = 0; ne2 = 0;
   endtask

   task automatic pix(input int x, input int y, input bit sof);
      bit v1, v2, e1, e2;
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = 8'(y * 6 + x);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      v1 = (x >= 2) && (y >= 2);
      e1 = (x == 5) && (y == 5);
      v2 = v1 && (x % 2 == 0) && (y % 2 == 0);
      e2 = (x == 4) && (y == 4);
      if (v1) w1 = wexp(x, y);
      if (v2) w2 = wexp(x, y);
      chk("valid_s1", 72'(ov1), 72'(v1));
      chk("eof_s1", 72'(oe1), 72'(e1));
      chk("win_s1", win1, w1);
      chk("valid_s2", 72'(ov2), 72'(v2));
      chk("eof_s2", 72'(oe2), 72'(e2));
      chk("win_s2", win2, w2);
      nv1 += int'(ov1); ne1 += int'(oe1);
      nv2 += int'(ov2); ne2 += int'(oe2);
   endtask

   // Idle cycle with junk on data/sof: nothing may be emitted and win must hold
   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'($urandom);
      in_data  = 8'($urandom);
      @(posedge clk);
      #1;
      chk("idle_valid_s1", 72'(ov1), 72'd0);
      chk("idle_valid_s2", 72'(ov2), 72'd0);
      chk("idle_eof", 72'(oe1 | oe2), 72'd0);
      chk("idle_hold_s1", win1, w1);
      chk("idle_hold_s2", win2, w2);
   endtask

   task automatic frame(input bit sof, input bit gaps, input int n);
      for (int i = 0; i < n; i++) begin
         if (gaps)
            for (int k = 0; k < 4 && $urandom_range(0, 99) < 60; k++) idle();
         pix(i % 6, i / 6, sof && (i == 0));
      end
   endtask

   task automatic chk_counts(input string tag, input int a, input int b, input int c, input int d);
      chk({tag, "_nwin_s1"}, 72'(nv1), 72'(a));
      chk({tag, "_neof_s1"}, 72'(ne1), 72'(b));
      chk({tag, "_nwin_s2"}, 72'(nv2), 72'(c));
      chk({tag, "_neof_s2"}, 72'(ne2), 72'(d));
   endtask

   initial begin
      rstn = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
      w1 = '0; w2 = '0;
      #12;
      chk("rst_valid", 72'(ov1 | ov2), 72'd0);
      chk("rst_eof", 72'(oe1 | oe2), 72'd0);
      chk("rst_win_s1", win1, 72'd0);
      chk("rst_win_s2", win2, 72'd0);
      rstn = 1'b1;

      clr_cnt(); frame(1'b1, 1'b0, 36); chk_counts("basic", 16, 1, 4, 1);
      clr_cnt(); frame(1'b0, 1'b1, 36); chk_counts("gaps", 16, 1, 4, 1);
      clr_cnt(); frame(1'b0, 1'b0, 36); frame(1'b0, 1'b0, 36);
      chk_counts("b2b", 32, 2, 8, 2);

      // abort after (2,3); the sof pixel lands where (3,3) would have been
      clr_cnt(); frame(1'b0, 1'b0, 21); frame(1'b1, 1'b0, 36);
      chk_counts("resync", 21, 1, 6, 1);

      // reset just after the (3,3) window is presented
      frame(1'b0, 1'b0, 22);
      chk("pre_rst_valid", 72'(ov1), 72'd1);
      #1 rstn = 1'b0;
      #1;
      chk("async_rst_valid", 72'(ov1 | ov2), 72'd0);
      chk("async_rst_eof", 72'(oe1 | oe2), 72'd0);
      chk("async_rst_win_s1", win1, 72'd0);
      chk("async_rst_win_s2", win2, 72'd0);
      w1 = '0; w2 = '0;
      #1 rstn = 1'b1;
      clr_cnt(); frame(1'b0, 1'b0, 36); chk_counts("post_rst", 16, 1, 4, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
